// File: rtl/iram_sync_fifo_pkg.sv
// Shared sizing helpers and defaults for the iram FIFO and its backing RAM.
package iram_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AW    = 6;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than an address.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/iram_sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and iram_sync_fifo.
interface iram_sync_fifo_if
  import iram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic                 flush;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [WIDTH-1:0]     rd_data;
  logic [cnt_w(AW)-1:0] count;
  logic                 almost_full;
  logic                 almost_empty;

  modport master (
    output flush, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, almost_full, almost_empty
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, almost_full, almost_empty
  );

endinterface

// File: rtl/iram_sync_fifo_ram.sv
// Simple dual-port RAM, one clock, registered read data; no reset so it maps onto block RAM.
module iram_1r1w1ck_p
  import iram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             ena,
  input  logic             wea,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dia,
  input  logic             enb,
  input  logic [AW-1:0]    addrb,
  output logic [WIDTH-1:0] dob
);

  localparam int DEPTH = depth_of(AW);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];

  // Write port A and registered read port B
  always_ff @(posedge clk) begin
    if (ena && wea) begin
      mem_q[addra] <= dia;
    end
    if (enb) begin
      dob <= mem_q[addrb];
    end
  end

endmodule

// File: rtl/iram_sync_fifo.sv
// First-word-fall-through FIFO: RAM holds the backlog, the RAM read register is the output stage.
module iram_sync_fifo
  import iram_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int AW         = DEF_AW,
  parameter int AFULL_LVL  = 56,
  parameter int AEMPTY_LVL = 8
) (
  input  logic            clk,
  input  logic            reset,
  iram_sync_fifo_if.slave fifo
);

  localparam int DEPTH = depth_of(AW);
  localparam int CW    = cnt_w(AW);

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LVL);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(0);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;

  logic             wr_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             rd_issue_s;
  logic             clear_s;
  logic [CW-1:0]    ram_cnt_s;
  logic [WIDTH-1:0] dob_s;

  assign wr_ready_s = (count_q != FULL_CNT);
  assign clear_s    = reset | fifo.flush;

  // Next-state for pointers, occupancy, output-valid flag and watermarks
  always_comb begin
    push_s     = fifo.wr_valid & wr_ready_s;
    pop_s      = rd_valid_q & fifo.rd_ready;
    // Words still in RAM; only those written at an earlier edge are counted.
    ram_cnt_s  = count_q - {{AW{1'b0}}, rd_valid_q};
    rd_issue_s = (!rd_valid_q || pop_s) && (ram_cnt_s != CNT_ZERO);

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;

    if (fifo.flush) begin
      wptr_d     = PTR_ZERO;
      rptr_d     = PTR_ZERO;
      count_d    = CNT_ZERO;
      rd_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end

      if (rd_issue_s) begin
        rptr_d     = rptr_q + PTR_ONE;
        rd_valid_d = 1'b1;
      end else if (pop_s) begin
        rd_valid_d = 1'b0;
      end else begin
        rd_valid_d = rd_valid_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    afull_d  = (count_d >= AFULL_CNT);
    aempty_d = (count_d <= AEMPTY_CNT);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= PTR_ZERO;
      rptr_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      rd_valid_q <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  iram_1r1w1ck_p #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .ena   (push_s & ~clear_s),
    .wea   (1'b1),
    .addra (wptr_q),
    .dia   (fifo.wr_data),
    .enb   (rd_issue_s & ~clear_s),
    .addrb (rptr_q),
    .dob   (dob_s)
  );

  // Data is masked while the output stage is empty so it reads as zero after reset.
  assign fifo.rd_data      = rd_valid_q ? dob_s : {WIDTH{1'b0}};
  assign fifo.rd_valid     = rd_valid_q;
  assign fifo.wr_ready     = wr_ready_s;
  assign fifo.count        = count_q;
  assign fifo.almost_full  = afull_q;
  assign fifo.almost_empty = aempty_q;

endmodule

// File: tb/tb_iram_sync_fifo.sv
// Directed and randomised checks of iram_sync_fifo against a scoreboard queue.
module tb_iram_sync_fifo;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  iram_sync_fifo_if #(.WIDTH(32), .AW(6)) f();

  iram_sync_fifo #(
    .WIDTH      (32),
    .AW         (6),
    .AFULL_LVL  (56),
    .AEMPTY_LVL (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (f)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mcount;
  bit          mvalid;
  logic [31:0] mq[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check_val("cnt", 64'(f.count), 64'(mcount));
    check_val("rd_valid", 64'(f.rd_valid), 64'(mvalid));
    check_val("wr_ready", 64'(f.wr_ready), 64'(mcount != 64));
    check_val("afull", 64'(f.almost_full), 64'(mcount >= 56));
    check_val("aempty", 64'(f.almost_empty), 64'(mcount <= 8));
    if (mvalid && mq.size() > 0) begin
      check_val("rd_data", 64'(f.rd_data), 64'(mq[0]));
    end
  endtask

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic cycle(input bit fl, input bit wv, input logic [31:0] wd, input bit rr);
    bit push;
    bit pop;
    bit issue;
    int ram;
    f.flush    = fl;
    f.wr_valid = wv;
    f.wr_data  = wd;
    f.rd_ready = rr;
    push = wv && (mcount != 64);
    pop  = mvalid && rr;
    if (fl) begin
      mq.delete();
      mcount = 0;
      mvalid = 1'b0;
    end else begin
      ram   = mcount - int'(mvalid);
      issue = (ram > 0) && (!mvalid || pop);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(wd);
      mcount = mcount + int'(push) - int'(pop);
      if (issue) mvalid = 1'b1;
      else if (pop) mvalid = 1'b0;
    end
    @(posedge clk);
    #1;
    f.flush    = 1'b0;
    f.wr_valid = 1'b0;
    f.rd_ready = 1'b0;
    check_model();
  endtask

  initial begin
    reset      = 1'b1;
    f.flush    = 1'b0;
    f.wr_valid = 1'b0;
    f.wr_data  = 32'h0;
    f.rd_ready = 1'b0;
    mcount     = 0;
    mvalid     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_count", 64'(f.count), 64'd0);
    check_val("rst_rd_valid", 64'(f.rd_valid), 64'd0);
    check_val("rst_wr_ready", 64'(f.wr_ready), 64'd1);
    check_val("rst_afull", 64'(f.almost_full), 64'd0);
    check_val("rst_aempty", 64'(f.almost_empty), 64'd1);
    check_val("rst_rd_data", 64'(f.rd_data), 64'd0);

    // Single word: visible one edge after the push
    cycle(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    check_val("t1_cnt", 64'(f.count), 64'd1);
    check_val("t1_rdv_early", 64'(f.rd_valid), 64'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check_val("t1_rdv", 64'(f.rd_valid), 64'd1);
    check_val("t1_data", 64'(f.rd_data), 64'hA5A5A5A5);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_val("t1_cnt_pop", 64'(f.count), 64'd0);
    check_val("t1_aempty", 64'(f.almost_empty), 64'd1);

    // Fill to capacity with watermark edges
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 32'(i), 1'b0);
      if (i == 7)  check_val("t2_ae_at8", 64'(f.almost_empty), 64'd1);
      if (i == 8)  check_val("t2_ae_at9", 64'(f.almost_empty), 64'd0);
      if (i == 54) check_val("t2_af_at55", 64'(f.almost_full), 64'd0);
      if (i == 55) check_val("t2_af_at56", 64'(f.almost_full), 64'd1);
    end
    check_val("t2_wr_ready", 64'(f.wr_ready), 64'd0);
    check_val("t2_cnt", 64'(f.count), 64'd64);
    check_val("t2_afull", 64'(f.almost_full), 64'd1);
    cycle(1'b0, 1'b1, 32'h99, 1'b0);
    check_val("t2_cnt_ovf", 64'(f.count), 64'd64);

    // Full: pop with a refused push
    cycle(1'b0, 1'b1, 32'h77, 1'b1);
    check_val("t3_cnt", 64'(f.count), 64'd63);
    check_val("t3_wr_ready", 64'(f.wr_ready), 64'd1);
    check_val("t3_data", 64'(f.rd_data), 64'd1);

    // Streaming through several pointer wraps
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 1'b1, 32'(1000 + i), 1'b1);
      check_val("t4_cnt", 64'(f.count), 64'd63);
    end

    // Flush at count 20 with a simultaneous push and pop
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 32'(32'h500 + i), 1'b0);
    check_val("t5_cnt20", 64'(f.count), 64'd20);
    cycle(1'b1, 1'b1, 32'hDEAD, 1'b1);
    check_val("t5_cnt", 64'(f.count), 64'd0);
    check_val("t5_rdv", 64'(f.rd_valid), 64'd0);
    check_val("t5_wr_ready", 64'(f.wr_ready), 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'(32'h600 + i), 1'b0);
    check_val("t5_first", 64'(f.rd_data), 64'h600);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_val("t5_drained", 64'(f.count), 64'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
